// File: rtl/stepper_pkg.sv
// Shared definitions for the bus stepper.
//   MODE_*    : encodings of the 2-bit mode select
//   state_t   : grant FSM states (S_WAIT idle/withholding, S_EXEC cycle granted)
//   debounce_w: width of the debounce stability counter for a given length
package stepper_pkg;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_BREAK = 2'b11;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  // clog2(n+1), never less than 1 so a bypassed filter still has a legal width.
  function automatic int debounce_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/step_debouncer.sv
// Step switch conditioner: 2-FF synchroniser, stability filter and a
// one-clock pulse on the rising edge of the filtered level.
// All state changes on the falling edge of clk.
//   clk        : master clock (falling-edge active)
//   rst_n      : asynchronous active-low reset
//   step_raw   : raw push-switch, asynchronous, active-high
//   step_pulse : high for one clock after the filtered level rises
// DEBOUNCE_CYCLES = 0 bypasses the filter (synchroniser only).
module step_debouncer
  import stepper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_raw,
  output logic step_pulse
);

  localparam int DW = debounce_w(DEBOUNCE_CYCLES);

  logic sync1, sync2;
  logic level, level_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= step_raw;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign level = sync2;
    end else begin : g_filter
      localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
      logic [DW-1:0] cnt;
      logic          level_r;

      // The level flips on the DEBOUNCE_CYCLES-th consecutive edge that the
      // synchronised input disagrees with it; any agreement restarts the run.
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt     <= '0;
          level_r <= 1'b0;
        end else if (sync2 != level_r) begin
          if (cnt == LAST) begin
            level_r <= sync2;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end

      assign level = level_r;
    end
  endgenerate

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign step_pulse = level & ~level_q;

endmodule

// File: rtl/bus_stepper.sv
// Bus-cycle stepper: gates each CPU bus cycle (one ENABLE_IN high span) onto
// ENABLE_EXECUTE according to MODE_IN (free run, single step, N-cycle burst,
// run-to-breakpoint). State changes on the falling edge of MCLK_IN.
//   MCLK_IN        : master clock
//   RUN_IN         : asynchronous active-low reset
//   MODE_IN        : 00 RUN, 01 STEP, 10 BURST, 11 BREAK
//   STEP_IN        : raw step switch
//   ENABLE_IN      : bus cycle request, high for one cycle
//   BURST_LEN_IN   : cycles granted per press in BURST mode (0 means 1)
//   ADDR_IN        : CPU address, valid while ENABLE_IN is high
//   BREAK_ADDR_IN  : breakpoint address
//   ENABLE_EXECUTE : registered grant for the current bus cycle
//   PAUSED         : registered, a cycle is requested but withheld
//   BREAK_HIT      : registered, breakpoint match latched
//   CYCLE_CNT      : granted cycles, modulo 2^CNT_W
// Optional feature macro: BUS_STEPPER_BREAKPOINT_EN enables BREAK mode;
// without it mode 11 runs free and BREAK_HIT is 0.
//
// Handshake: a request is the ENABLE_IN high span. The grant is sampled on
// the first edge of the span only (S_WAIT); once granted, ENABLE_EXECUTE
// follows the span until ENABLE_IN is seen low, so one span gets at most one
// grant and a new span needs ENABLE_IN low for at least one edge.
module bus_stepper
  import stepper_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int ADDR_W          = 24,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic              MCLK_IN,
  input  logic              RUN_IN,
  input  logic [1:0]        MODE_IN,
  input  logic              STEP_IN,
  input  logic              ENABLE_IN,
  input  logic [CNT_W-1:0]  BURST_LEN_IN,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [ADDR_W-1:0] BREAK_ADDR_IN,
  output logic              ENABLE_EXECUTE,
  output logic              PAUSED,
  output logic              BREAK_HIT,
  output logic [CNT_W-1:0]  CYCLE_CNT
);

  state_t           state;
  logic [CNT_W-1:0] credit;
  logic             brk_hit_q;
  logic             step_evt;

  logic             run_like;     // grants without credit
  logic             credit_mode;  // grants consume credit, steps load it
  logic             brk_match;
  logic             allow;
  logic             take_credit;
  logic             load_credit;
  logic [CNT_W-1:0] load_val;

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (MCLK_IN),
    .rst_n     (RUN_IN),
    .step_raw  (STEP_IN),
    .step_pulse(step_evt)
  );

  always_comb begin
    run_like    = 1'b0;
    credit_mode = 1'b0;
    brk_match   = 1'b0;
    case (MODE_IN)
      MODE_RUN:              run_like    = 1'b1;
      MODE_STEP, MODE_BURST: credit_mode = 1'b1;
      default: begin
`ifdef BUS_STEPPER_BREAKPOINT_EN
        // After a hit the block single-steps; the stepped cycle is not
        // compared again, so it cannot re-trigger.
        if (brk_hit_q) begin
          credit_mode = 1'b1;
        end else begin
          run_like  = 1'b1;
          brk_match = (ADDR_IN == BREAK_ADDR_IN);
        end
`else
        run_like = 1'b1;
`endif
      end
    endcase

    allow       = credit_mode ? (credit != '0) : (run_like && !brk_match);
    take_credit = (state == S_WAIT) && ENABLE_IN && credit_mode && (credit != '0);
    // A step landing on a grant edge only loads an empty counter, so the
    // grant always sees the old credit.
    load_credit = step_evt && credit_mode && (credit == '0);
    if (MODE_IN == MODE_BURST)
      load_val = (BURST_LEN_IN == '0) ? CNT_W'(1) : BURST_LEN_IN;
    else
      load_val = CNT_W'(1);
  end

  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      state          <= S_WAIT;
      credit         <= '0;
      ENABLE_EXECUTE <= 1'b0;
      PAUSED         <= 1'b0;
      CYCLE_CNT      <= '0;
    end else begin
      if (!credit_mode)     credit <= '0;
      else if (take_credit) credit <= credit - 1'b1;
      else if (load_credit) credit <= load_val;

      case (state)
        S_WAIT: begin
          if (ENABLE_IN) begin
            if (allow) begin
              ENABLE_EXECUTE <= 1'b1;
              PAUSED         <= 1'b0;
              CYCLE_CNT      <= CYCLE_CNT + 1'b1;
              state          <= S_EXEC;
            end else begin
              PAUSED <= 1'b1;
            end
          end else begin
            PAUSED <= 1'b0;
          end
        end
        S_EXEC: begin
          if (!ENABLE_IN) begin
            ENABLE_EXECUTE <= 1'b0;
            state          <= S_WAIT;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

`ifdef BUS_STEPPER_BREAKPOINT_EN
  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      brk_hit_q <= 1'b0;
    end else if (MODE_IN != MODE_BREAK) begin
      brk_hit_q <= 1'b0;
    end else if ((state == S_WAIT) && ENABLE_IN) begin
      if (allow)          brk_hit_q <= 1'b0;
      else if (brk_match) brk_hit_q <= 1'b1;
    end
  end
`else
  logic unused_addr;
  assign unused_addr = ^{ADDR_IN, BREAK_ADDR_IN};
  assign brk_hit_q   = 1'b0;
`endif

  assign BREAK_HIT = brk_hit_q;

endmodule

// File: tb/tb_bus_stepper.sv
module tb_bus_stepper;

  localparam int M_RUN   = 0;
  localparam int M_STEP  = 1;
  localparam int M_BURST = 2;
  localparam int M_BREAK = 3;

  logic        mclk;
  logic        run_n;
  logic [1:0]  mode;
  logic        step;
  logic        enable;
  logic [7:0]  burst_len;
  logic [23:0] addr;
  logic [23:0] break_addr;
  logic        enable_execute;
  logic        paused;
  logic        break_hit;
  logic [7:0]  cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Span-level reference model: remaining granted cycles and granted count.
  int m_mode   = M_RUN;
  int m_credit = 0;
  int m_cnt    = 0;

  bus_stepper #(
    .CNT_W(8),
    .ADDR_W(24),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .MCLK_IN       (mclk),
    .RUN_IN        (run_n),
    .MODE_IN       (mode),
    .STEP_IN       (step),
    .ENABLE_IN     (enable),
    .BURST_LEN_IN  (burst_len),
    .ADDR_IN       (addr),
    .BREAK_ADDR_IN (break_addr),
    .ENABLE_EXECUTE(enable_execute),
    .PAUSED        (paused),
    .BREAK_HIT     (break_hit),
    .CYCLE_CNT     (cycle_cnt)
  );

  // Clock: DUT acts on falling edges; the bench drives and samples on rising.
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic set_mode(input int m);
    mode   = 2'(m);
    m_mode = m;
    if (m == M_RUN || m == M_BREAK) m_credit = 0;
  endtask

  // Bouncy press, held, then released long enough for the filter to settle.
  task automatic press(input int hold);
    step = 1'b1; @(posedge mclk);
    step = 1'b0; @(posedge mclk);
    step = 1'b1; @(posedge mclk);
    repeat (hold) @(posedge mclk);
    step = 1'b0;
    repeat (12) @(posedge mclk);
    if ((m_mode == M_STEP || m_mode == M_BURST) && m_credit == 0)
      m_credit = (m_mode == M_BURST) ? ((burst_len == 0) ? 1 : int'(burst_len)) : 1;
  endtask

  task automatic run_span(input int len, input logic [23:0] a, input string name);
    bit exp_g;
    exp_g = (m_mode == M_RUN || m_mode == M_BREAK) || (m_credit > 0);
    if (exp_g && !(m_mode == M_RUN || m_mode == M_BREAK)) m_credit--;
    if (exp_g) m_cnt = (m_cnt + 1) % 256;
    addr   = a;
    enable = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(posedge mclk);
      n_checks++;
      if (enable_execute !== exp_g) begin
        n_fail++;
        $display("FAIL %s ee got %b exp %b", name, enable_execute, exp_g);
      end
      n_checks++;
      if (paused !== !exp_g) begin
        n_fail++;
        $display("FAIL %s paused got %b exp %b", name, paused, !exp_g);
      end
    end
    enable = 1'b0;
    @(posedge mclk);
    n_checks++;
    if (enable_execute !== 1'b0 || paused !== 1'b0 || break_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end ee/paused/hit got %b%b%b exp 000", name, enable_execute, paused, break_hit);
    end
    n_checks++;
    if (cycle_cnt !== 8'(m_cnt)) begin
      n_fail++;
      $display("FAIL %s cnt got %0d exp %0d", name, cycle_cnt, m_cnt);
    end
  endtask

  task automatic test_reset();
    run_n = 1'b0;
    repeat (3) @(posedge mclk);
    n_checks++;
    if ({enable_execute, paused, break_hit} !== 3'b000 || cycle_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset got ee/p/h %b%b%b cnt %0d exp 000 cnt 0", enable_execute, paused, break_hit, cycle_cnt);
    end
    run_n = 1'b1;
    @(posedge mclk);
  endtask

  task automatic test_run();
    set_mode(M_RUN);
    for (int i = 0; i < 5; i++) run_span(4, 24'(i * 2), "run");
  endtask

  task automatic test_step_hold();
    set_mode(M_STEP);
    step = 1'b1; @(posedge mclk);
    step = 1'b0; @(posedge mclk);
    step = 1'b1; @(posedge mclk);
    repeat (10) @(posedge mclk);
    m_credit = 1;
    run_span(3, 24'h10, "step_span1");
    run_span(3, 24'h12, "step_span2");
    run_span(3, 24'h14, "step_span3");
    step = 1'b0;
    repeat (12) @(posedge mclk);
  endtask

  // Three sampled edges high is one short of the stability run.
  task automatic test_glitch();
    set_mode(M_STEP);
    step = 1'b1;
    repeat (3) @(posedge mclk);
    step = 1'b0;
    repeat (12) @(posedge mclk);
    run_span(2, 24'h20, "glitch");
  endtask

  task automatic test_burst();
    set_mode(M_BURST);
    burst_len = 8'd3;
    press(10);
    run_span(2, 24'h30, "burst1");
    press(10);
    for (int i = 0; i < 4; i++) run_span(2, 24'(32'h32 + i * 2), "burst_rest");
    burst_len = 8'd0;
    press(10);
    run_span(2, 24'h40, "burst_len0_a");
    run_span(2, 24'h42, "burst_len0_b");
  endtask

`ifdef BUS_STEPPER_BREAKPOINT_EN
  task automatic test_break();
    break_addr = 24'h000400;
    set_mode(M_BREAK);
    run_span(2, 24'h0003FC, "brk_3fc");
    run_span(2, 24'h0003FE, "brk_3fe");
    addr   = 24'h000400;
    enable = 1'b1;
    repeat (3) @(posedge mclk);
    n_checks++;
    if ({enable_execute, paused, break_hit} !== 3'b011) begin
      n_fail++;
      $display("FAIL brk_hit ee/p/h got %b%b%b exp 011", enable_execute, paused, break_hit);
    end
    press(10);
    m_cnt = (m_cnt + 1) % 256;
    n_checks++;
    if ({enable_execute, paused, break_hit} !== 3'b100 || cycle_cnt !== 8'(m_cnt)) begin
      n_fail++;
      $display("FAIL brk_step ee/p/h got %b%b%b cnt %0d exp 100 cnt %0d",
               enable_execute, paused, break_hit, cycle_cnt, m_cnt);
    end
    enable = 1'b0;
    @(posedge mclk);
    run_span(2, 24'h000402, "brk_402");
    addr   = 24'h000400;
    enable = 1'b1;
    @(posedge mclk);
    n_checks++;
    if (break_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL brk_rehit got %b exp 1", break_hit);
    end
    set_mode(M_RUN);
    @(posedge mclk);
    m_cnt = (m_cnt + 1) % 256;
    n_checks++;
    if ({enable_execute, paused, break_hit} !== 3'b100) begin
      n_fail++;
      $display("FAIL brk_leave ee/p/h got %b%b%b exp 100", enable_execute, paused, break_hit);
    end
    enable = 1'b0;
    @(posedge mclk);
  endtask
`else
  task automatic test_break();
    break_addr = 24'h000400;
    set_mode(M_BREAK);
    run_span(2, 24'h000400, "mode3_match");
    run_span(2, 24'h000402, "mode3_other");
    set_mode(M_RUN);
  endtask
`endif

  task automatic test_reset_mid();
    set_mode(M_BURST);
    burst_len = 8'd3;
    press(10);
    enable = 1'b1;
    repeat (2) @(posedge mclk);
    n_checks++;
    if (enable_execute !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre ee got %b exp 1", enable_execute);
    end
    #2 run_n = 1'b0;
    #1;
    n_checks++;
    if (enable_execute !== 1'b0 || paused !== 1'b0 || cycle_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid ee/p got %b%b cnt %0d exp 00 cnt 0", enable_execute, paused, cycle_cnt);
    end
    m_cnt    = 0;
    m_credit = 0;
    @(posedge mclk);
    run_n  = 1'b1;
    enable = 1'b0;
    @(posedge mclk);
    set_mode(M_STEP);
    run_span(2, 24'h50, "rst_after");
  endtask

  task automatic test_mode_switch();
    set_mode(M_STEP);
    addr   = 24'h60;
    enable = 1'b1;
    @(posedge mclk);
    n_checks++;
    if ({enable_execute, paused} !== 2'b01) begin
      n_fail++;
      $display("FAIL sw_paused ee/p got %b%b exp 01", enable_execute, paused);
    end
    set_mode(M_RUN);
    @(posedge mclk);
    m_cnt = (m_cnt + 1) % 256;
    n_checks++;
    if ({enable_execute, paused} !== 2'b10) begin
      n_fail++;
      $display("FAIL sw_grant ee/p got %b%b exp 10", enable_execute, paused);
    end
    enable = 1'b0;
    @(posedge mclk);
    n_checks++;
    if (enable_execute !== 1'b0 || cycle_cnt !== 8'(m_cnt)) begin
      n_fail++;
      $display("FAIL sw_end ee got %b cnt %0d exp 0 cnt %0d", enable_execute, cycle_cnt, m_cnt);
    end
  endtask

  task automatic test_random();
    int r;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        set_mode($urandom_range(0, 2));
      end else if (r < 4) begin
        burst_len = 8'($urandom_range(0, 4));
        press(10);
      end else begin
        run_span($urandom_range(1, 5), 24'($urandom), "rand");
      end
      repeat ($urandom_range(0, 2)) @(posedge mclk);
    end
  endtask

  task automatic test_wrap();
    set_mode(M_RUN);
    for (int i = 0; i < 258; i++) run_span(1, 24'(i), "wrap");
  endtask

  initial begin
    run_n      = 1'b0;
    mode       = 2'b00;
    step       = 1'b0;
    enable     = 1'b0;
    burst_len  = 8'd0;
    addr       = '0;
    break_addr = 24'h000400;
    @(posedge mclk);
    test_reset();
    test_run();
    test_step_hold();
    test_glitch();
    test_burst();
    test_break();
    test_reset_mid();
    test_mode_switch();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_stepper.md
Name: bus_stepper

Overview:
- Parametrised successor to the single-step DTACK gate in the 68000 FPGA glue.
- Gates each CPU bus cycle (ENABLE_IN high span) onto ENABLE_EXECUTE according to the selected mode: free run, single step, N-cycle burst, or run-to-breakpoint.
- Adds on-chip switch debounce, a cycle credit counter and a granted-cycle counter.
- Sits between the bus-cycle decoder and the DTACK driver.

Parameters:
- CNT_W, 8: width of the burst length, the credit counter and CYCLE_CNT.
- ADDR_W, 24: width of the address compare bus.
- DEBOUNCE_CYCLES, 1024: stable MCLK cycles required on STEP; 0 bypasses the filter (2-FF sync only).

Ports:
- MCLK_IN  in  1  master clock; all state updates on the falling edge.
- RUN_IN  in  1  asynchronous active-low reset.
- MODE_IN  in  2  mode select: 00 RUN, 01 STEP, 10 BURST, 11 BREAK.
- STEP_IN  in  1  raw step push-switch, asynchronous, active-high.
- ENABLE_IN  in  1  bus cycle request; high for the duration of one cycle.
- BURST_LEN_IN  in  CNT_W  cycles granted per press in BURST mode.
- ADDR_IN  in  ADDR_W  CPU address, valid while ENABLE_IN is high.
- BREAK_ADDR_IN  in  ADDR_W  breakpoint address.
- ENABLE_EXECUTE  out  1  registered grant for the current bus cycle.
- PAUSED  out  1  registered; a cycle is requested but withheld.
- BREAK_HIT  out  1  registered; breakpoint match latched.
- CYCLE_CNT  out  CNT_W  granted bus cycles, wraps modulo 2^CNT_W.

Behaviour:
- Reset (RUN_IN low, asynchronous): ENABLE_EXECUTE=0, PAUSED=0, BREAK_HIT=0, CYCLE_CNT=0, credit=0, debounced step=0, sync FFs=0, FSM in S_WAIT.
- Step event: a single-edge pulse on the rising edge of the debounced STEP level.
  - Debounced level flips only after the synced input differs from it for DEBOUNCE_CYCLES consecutive edges.
  - Holding the switch yields exactly one event.
- Credit loading (edge E of the step event; a grant can use it no earlier than E+1):
  - STEP: credit:=1, but only if credit==0.
  - BURST: credit:=BURST_LEN_IN, but only if credit==0. A value of 0 loads 1.
  - RUN: credit is held at 0 and step events are ignored.
- FSM S_WAIT (ENABLE_EXECUTE=0):
  - If ENABLE_IN=1 and a grant is allowed: ENABLE_EXECUTE<=1, CYCLE_CNT+=1, move to S_EXEC.
  - Grant is allowed when the mode is RUN, or credit!=0 (credit decrements), or BREAK mode with no match.
  - Else if ENABLE_IN=1: PAUSED<=1.
  - PAUSED<=0 on the same edge a grant is issued, or when ENABLE_IN drops.
- FSM S_EXEC:
  - ENABLE_EXECUTE stays 1 while ENABLE_IN=1.
  - When ENABLE_IN=0: ENABLE_EXECUTE<=0, return to S_WAIT.
  - At most one grant per ENABLE_IN high span; a new span needs ENABLE_IN low for at least one edge.
- Simultaneous events:
  - Step event and grant decision on the same edge: the load applies, and the grant uses the old credit.
  - ENABLE_IN falling on the grant edge: the grant is not issued.
- Mode change:
  - Sampled every edge; affects only the next S_WAIT decision, never a cycle in S_EXEC.
  - Entering RUN clears credit.
- Reset mid-cycle: ENABLE_EXECUTE drops immediately (asynchronous).

Optional Feature:
- Macro: BUS_STEPPER_BREAKPOINT_EN.
- Defined, BREAK mode (11):
  - Behaves as RUN until ADDR_IN==BREAK_ADDR_IN is compared in S_WAIT with ENABLE_IN=1.
  - On that match the cycle is withheld, BREAK_HIT<=1, PAUSED<=1.
  - While BREAK_HIT=1 the block acts as STEP mode, and a granted cycle clears BREAK_HIT.
  - The matching cycle granted by a step does not re-trigger the breakpoint.
  - Leaving BREAK mode clears BREAK_HIT.
- Not defined: MODE 11 behaves as RUN, BREAK_HIT is tied to 0, and the comparator is absent.

Decomposition:
- Package stepper_pkg:
  - Mode constants MODE_RUN/MODE_STEP/MODE_BURST/MODE_BREAK.
  - FSM state typedef (S_WAIT, S_EXEC).
  - Debounce counter width function clog2(DEBOUNCE_CYCLES+1).
- Sub-module step_debouncer: 2-FF synchroniser, stability counter and rising-edge pulse; parameter DEBOUNCE_CYCLES.

Test Plan:
- RUN, 5 bus cycles of 4 clocks each -> ENABLE_EXECUTE high from 1 edge after each ENABLE_IN rise to 1 edge after its fall; CYCLE_CNT=5; PAUSED never asserted.
- STEP, DEBOUNCE_CYCLES=4, 3 ENABLE_IN spans, STEP bouncing for 3 edges then held high for 20 -> exactly 1 grant; PAUSED=1 during spans 2 and 3; CYCLE_CNT=1.
- BURST, BURST_LEN_IN=3, one press, 5 spans -> spans 1-3 granted, spans 4-5 paused; a second press during the burst is ignored; BURST_LEN_IN=0 grants 1.
- Macro on, BREAK, BREAK_ADDR_IN=24'h000400, addresses 0x3FC/0x3FE/0x400 -> first two granted, third withheld with BREAK_HIT=1; one press grants 0x400 and BREAK_HIT=0; 0x402 runs free.
- RUN_IN low for 1 clock mid-S_EXEC -> ENABLE_EXECUTE=0 within the same clock; CYCLE_CNT=0, credit=0; after release in STEP mode the next span is paused.
- Mode STEP->RUN while paused with credit 0 -> the span is granted at the next edge and PAUSED clears.
